bht_predictor: RTL



---
 rtl/bht_pkg.sv | 25 ++
 rtl/bht_predictor_sat_counter.sv | 19 +
 rtl/bht_predictor.sv | 111 +++++++++++
 3 files changed

// File: rtl/bht_pkg.sv
// Shared definitions for the dynamic branch predictor: static fallback policy
// codes, predictor state encoding and the fallback decision helper.
package bht_pkg;

  localparam int unsigned NOT_TAKEN = 0;
  localparam int unsigned TAKEN     = 1;
  localparam int unsigned BTFNT     = 2;

  typedef enum logic {
    INIT,
    READY
  } state_t;

  // Static prediction used whenever the table cannot answer; unknown modes act as not-taken.
  function automatic logic fallback_pred(input int unsigned mode,
                                         input logic [31:0] pc,
                                         input logic [31:0] pc_next);
    case (mode)
      TAKEN:   return 1'b1;
      BTFNT:   return pc_next < pc;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/bht_predictor_sat_counter.sv
// Combinational next value of a saturating up/down counter, clamped at 0 and all-ones.
module sat_counter #(
  parameter int unsigned WIDTH = 2
) (
  input  logic [WIDTH-1:0] i_cnt,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_cnt
);

  always_comb begin
    o_cnt = i_cnt;
    if (i_inc) begin
      if (i_cnt != '1) o_cnt = i_cnt + 1'b1;
    end else begin
      if (i_cnt != '0) o_cnt = i_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/bht_predictor.sv
// Direct-mapped tagged branch history table with saturating counters; falls back
// to a static policy on a miss or while the table is being swept after reset.
module bht_predictor
  import bht_pkg::*;
#(
  parameter int unsigned SIZE_WIDTH    = 6,
  parameter int unsigned COUNTER_WIDTH = 2,
  parameter int unsigned FALLBACK_MODE = BTFNT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  input  logic [31:0] pc_next_i,
  output logic        taken_o,
  output logic        hit_o,
  output logic        ready_o,
  input  logic        update_en_i,
  input  logic [31:0] update_pc_i,
  input  logic        update_taken_i
);

  localparam int unsigned SIZE      = 2**SIZE_WIDTH;
  localparam int unsigned TAG_WIDTH = 30 - SIZE_WIDTH;
  localparam int unsigned THR_I     = 2**(COUNTER_WIDTH-1);
  localparam logic [COUNTER_WIDTH-1:0] THR    = THR_I[COUNTER_WIDTH-1:0];
  localparam logic [COUNTER_WIDTH-1:0] THR_M1 = THR - 1'b1;

  typedef struct packed {
    logic                     valid;
    logic [TAG_WIDTH-1:0]     tag;
    logic [COUNTER_WIDTH-1:0] cnt;
  } entry_t;

  entry_t                r_tbl [SIZE];
  state_t                r_state;
  logic [SIZE_WIDTH-1:0] r_init_idx;

  logic                     w_live;
  logic [SIZE_WIDTH-1:0]    w_idx;
  logic [TAG_WIDTH-1:0]     w_tag;
  entry_t                   w_rd;
  logic                     w_hit;
  logic                     w_fallback;
  logic [SIZE_WIDTH-1:0]    w_uidx;
  logic [TAG_WIDTH-1:0]     w_utag;
  entry_t                   w_ue;
  logic                     w_uhit;
  logic [COUNTER_WIDTH-1:0] w_sat_cnt;
  entry_t                   w_new;
  logic                     w_unused_pc_lsbs;

  assign w_unused_pc_lsbs = ^{pc_i[1:0], update_pc_i[1:0]};

  // Reset is synchronous, so the table must read as offline during the rst cycle itself.
  assign w_live  = (r_state == READY) && !rst;
  assign ready_o = w_live;

  assign w_idx      = pc_i[SIZE_WIDTH+1:2];
  assign w_tag      = pc_i[31:SIZE_WIDTH+2];
  assign w_rd       = r_tbl[w_idx];
  assign w_hit      = w_live && w_rd.valid && (w_rd.tag == w_tag);
  assign w_fallback = fallback_pred(FALLBACK_MODE, pc_i, pc_next_i);
  assign hit_o      = w_hit;
  assign taken_o    = w_hit ? (w_rd.cnt >= THR) : w_fallback;

  assign w_uidx = update_pc_i[SIZE_WIDTH+1:2];
  assign w_utag = update_pc_i[31:SIZE_WIDTH+2];
  assign w_ue   = r_tbl[w_uidx];
  assign w_uhit = w_ue.valid && (w_ue.tag == w_utag);

  sat_counter #(
    .WIDTH (COUNTER_WIDTH)
  ) u_sat (
    .i_cnt (w_ue.cnt),
    .i_inc (update_taken_i),
    .o_cnt (w_sat_cnt)
  );

  always_comb begin
    w_new.valid = 1'b1;
    w_new.tag   = w_utag;
    if (w_uhit) begin
      w_new.cnt = w_sat_cnt;
    end else begin
      w_new.cnt = update_taken_i ? THR : THR_M1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= INIT;
      r_init_idx <= '0;
    end else begin
      case (r_state)
        INIT: begin
          r_tbl[r_init_idx] <= '{valid: 1'b0, tag: '0, cnt: THR_M1};
          r_init_idx        <= r_init_idx + 1'b1;
          if (r_init_idx == '1) r_state <= READY;
        end
        READY: begin
          if (update_en_i) r_tbl[w_uidx] <= w_new;
        end
        default: begin
          r_state    <= INIT;
          r_init_idx <= '0;
        end
      endcase
    end
  end

endmodule
